// File: rtl/elevator_controller.sv
// Elevator controller for NUM_FLOORS floors.
// Cabin and hall calls are latched into a pending bitmap and served with a
// SCAN policy: keep the current direction while requests remain that way,
// otherwise reverse. Travel and door dwell are timed in clk cycles. An
// emergency stop parks the car in HALT, and door_hold keeps the doors open.
// All outputs are decoded from registered state only.

module elevator_controller #(
   parameter int NUM_FLOORS    = 4,
   parameter int FLOOR_W       = 2,
   parameter int TRAVEL_CYCLES = 16,
   parameter int DOOR_CYCLES   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NUM_FLOORS-1:0] car_req,
   input  logic [NUM_FLOORS-1:0] hall_req,
   input  logic                  door_hold,
   input  logic                  estop,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  door_open,
   output logic                  moving,
   output logic                  dir_up,
   output logic                  halted
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] MOVING    = 2'd1;
   localparam logic [1:0] DOOR_OPEN = 2'd2;
   localparam logic [1:0] HALT      = 2'd3;

   // One shared down-counter serves both travel and door dwell.
   localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0]      TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [TW-1:0]      DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

   logic [1:0]            state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [FLOOR_W-1:0]    floor_q, floor_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic                  dir_q, dir_d;

   logic [NUM_FLOORS-1:0] req_now;
   logic [FLOOR_W-1:0]    step_floor;
   logic                  above_cur, below_cur, here_cur, go_up;
   logic                  above_next, below_next, here_next;

   // Any request strictly above floor f.
   function automatic logic req_above(input logic [NUM_FLOORS-1:0] v,
                                      input logic [FLOOR_W-1:0]    f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (FLOOR_W'(i) > f) r = r | v[i];
      end
      return r;
   endfunction

   // Any request strictly below floor f.
   function automatic logic req_below(input logic [NUM_FLOORS-1:0] v,
                                      input logic [FLOOR_W-1:0]    f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (FLOOR_W'(i) < f) r = r | v[i];
      end
      return r;
   endfunction

   // One-hot mask selecting floor f.
   function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (FLOOR_W'(i) == f) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Requests visible this cycle: latched ones plus buttons pressed right now.
   assign req_now = pending_q | car_req | hall_req;

   assign above_cur  = req_above(req_now, floor_q);
   assign below_cur  = req_below(req_now, floor_q);
   assign here_cur   = |(req_now & floor_mask(floor_q));
   assign go_up      = above_cur && (dir_q || !below_cur);

   assign above_next = req_above(req_now, step_floor);
   assign below_next = req_below(req_now, step_floor);
   assign here_next  = |(req_now & floor_mask(step_floor));

   // Neighbouring floor in the travel direction, clamped at the shaft ends.
   always_comb begin
      step_floor = floor_q;
      if (dir_q && floor_q != TOP_FLOOR) begin
         step_floor = floor_q + 1'b1;
      end else if (!dir_q && floor_q != '0) begin
         step_floor = floor_q - 1'b1;
      end
   end

   // Next-state logic: estop first, then enabled FSM stepping.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      timer_d = timer_q;
      floor_d = floor_q;
      dir_d   = dir_q;

      if (estop) begin
         state_d = HALT;
         timer_d = '0;
      end else if (enable) begin
         case (state_q)
            IDLE: begin
               if (here_cur) begin
                  state_d = DOOR_OPEN;
                  timer_d = DOOR_LOAD;
               end else if (go_up) begin
                  state_d = MOVING;
                  dir_d   = 1'b1;
                  timer_d = TRAVEL_LOAD;
               end else if (below_cur) begin
                  state_d = MOVING;
                  dir_d   = 1'b0;
                  timer_d = TRAVEL_LOAD;
               end
            end

            MOVING: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - 1'b1;
               end else begin
                  floor_d = step_floor;
                  if (here_next) begin
                     state_d = DOOR_OPEN;
                     timer_d = DOOR_LOAD;
                  end else if (dir_q ? above_next : below_next) begin
                     timer_d = TRAVEL_LOAD;
                  end else if (dir_q ? below_next : above_next) begin
                     dir_d   = !dir_q;
                     timer_d = TRAVEL_LOAD;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end

            DOOR_OPEN: begin
               if (door_hold) begin
                  timer_d = DOOR_LOAD;
               end else if (timer_q != '0) begin
                  timer_d = timer_q - 1'b1;
               end else if (go_up) begin
                  state_d = MOVING;
                  dir_d   = 1'b1;
                  timer_d = TRAVEL_LOAD;
               end else if (below_cur) begin
                  state_d = MOVING;
                  dir_d   = 1'b0;
                  timer_d = TRAVEL_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end

            default: begin
               // HALT: estop released, re-decide from IDLE with a full travel later.
               state_d = IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   // Latch new requests; the floor whose doors are (or become) open is served.
   always_comb begin
      pending_d = req_now;
      if (state_d == DOOR_OPEN) begin
         pending_d = req_now & ~floor_mask(floor_d);
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         floor_q   <= '0;
         pending_q <= '0;
         dir_q     <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
         state_q   <= state_d;
         timer_q   <= timer_d;
         floor_q   <= floor_d;
         pending_q <= pending_d;
         dir_q     <= dir_d;
      end
   end

   assign current_floor = floor_q;
   assign pending       = pending_q;
   assign door_open     = (state_q == DOOR_OPEN);
   assign moving        = (state_q == MOVING);
   assign halted        = (state_q == HALT);
   assign dir_up        = dir_q;

endmodule
